// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: each port owns one pending slot, and a small controller
// serialises the slots onto one shared memory port. Arbitration is round-robin or fixed priority.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;
endpackage

// One requester slot. nxt_* is the slot contents as they will look after this edge,
// so the controller can grant a request in the same cycle it is captured.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  req_t        in_req,
  input  logic        in_vld,
  input  logic        done,
  input  logic [31:0] m_rdata,
  output logic        pend,
  output logic        nxt_pend,
  output req_t        nxt_req,
  output logic [31:0] rdata
);
  req_t req_q;
  logic cap;

  // A busy port drops new strobes on the floor.
  assign cap      = in_vld & ~pend;
  assign nxt_pend = cap | (pend & ~done);
  assign nxt_req  = cap ? in_req : req_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend  <= 1'b0;
      req_q <= '0;
      rdata <= '0;
    end else begin
      pend <= nxt_pend;
      if (cap) req_q <= in_req;
      if (done && !req_q.write) rdata <= m_rdata;
    end
  end
endmodule

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int RR_ENABLE  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] p0_addr,
  input  logic        p0_rstrb,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic [31:0] p0_rdata,
  output logic        p0_rbusy,
  input  logic [31:0] p1_addr,
  input  logic        p1_rstrb,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic [31:0] p1_rdata,
  output logic        p1_rbusy,
  output logic [31:0] m_addr,
  output logic        m_rstrb,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic [31:0] m_rdata,
  input  logic        m_rbusy,
  output logic        m_owner
);
  localparam int NUM_PORTS = 2;
  localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << ADDR_WIDTH) - 64'd1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_n;
  logic   owner, prio, pick, any, load, done;

  req_t [NUM_PORTS-1:0]        in_req, nxt_req;
  logic [NUM_PORTS-1:0]        in_vld, pend, nxt_pend, done_vec;
  logic [NUM_PORTS-1:0][31:0]  rdata;
  req_t                        sel;

  // A request carrying both a read strobe and a byte mask is treated as a write.
  assign in_req[0] = '{write: |p0_wmask, addr: p0_addr, wdata: p0_wdata, wmask: p0_wmask};
  assign in_req[1] = '{write: |p1_wmask, addr: p1_addr, wdata: p1_wdata, wmask: p1_wmask};
  assign in_vld    = {p1_rstrb | (|p1_wmask), p0_rstrb | (|p0_wmask)};

  assign done = (state == WAIT) && !m_rbusy;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    assign done_vec[i] = done && (owner == 1'(i));
    mem_arbiter_slot u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_req   (in_req[i]),
      .in_vld   (in_vld[i]),
      .done     (done_vec[i]),
      .m_rdata  (m_rdata),
      .pend     (pend[i]),
      .nxt_pend (nxt_pend[i]),
      .nxt_req  (nxt_req[i]),
      .rdata    (rdata[i])
    );
  end

  // Candidates already exclude the slot completing this cycle, so a back-to-back
  // hand-over always goes to the other port.
  assign any  = |nxt_pend;
  assign pick = (&nxt_pend) ? ((RR_ENABLE != 0) ? prio : 1'b0) : nxt_pend[1];
  assign sel  = nxt_req[pick];

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: if (any) begin
        state_n = ISSUE;
        load    = 1'b1;
      end
      ISSUE: state_n = WAIT;
      WAIT: if (done) begin
        if (any) begin
          state_n = ISSUE;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rstrb <= 1'b0;
      m_wmask <= '0;
    end else begin
      state   <= state_n;
      m_rstrb <= 1'b0;
      m_wmask <= '0;
      if (load) begin
        owner   <= pick;
        prio    <= ~pick;
        m_addr  <= sel.addr & ADDR_MASK;
        m_wdata <= sel.wdata;
        m_rstrb <= ~sel.write;
        m_wmask <= sel.wmask;
      end
    end
  end

  assign m_owner  = owner;
  assign p0_rbusy = pend[0];
  assign p1_rbusy = pend[1];
  assign p0_rdata = rdata[0];
  assign p1_rdata = rdata[1];
endmodule
